// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/country signal controller slice:
// detector FSM state encoding and the country-road light encoding.
package traffic_pkg;

   // Debounce FSM states for the country-road loop detector
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      QUAL_ON  = 2'd1,
      PRESENT  = 2'd2,
      QUAL_OFF = 2'd3
   } det_state_t;

   // Country-road light encoding driven by the signal controller
   localparam logic [1:0] LIGHT_GREEN  = 2'd0;
   localparam logic [1:0] LIGHT_YELLOW = 2'd1;
   localparam logic [1:0] LIGHT_RED    = 2'd2;

   // True when the country light shows green, i.e. the road is being served
   function automatic logic is_served(input logic [1:0] light);
      return (light == LIGHT_GREEN);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input level.
// Reusable for any asynchronous control input of the controller.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_r;

   // Shift the raw level through the flop chain; cleared asynchronously
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         chain_r <= {STAGES{1'b0}};
      end else begin
         chain_r <= {chain_r[STAGES-2:0], d};
      end
   end

   assign q = chain_r[STAGES-1];

endmodule

// File: rtl/vehicle_detector.sv
// Country-road vehicle detector: synchronises and debounces the loop
// sensor, counts waiting vehicles and raises X until the road is served.
module vehicle_detector
   import traffic_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4,
   parameter int DCNT_W      = 3,
   parameter int QW          = 4
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          sensor_raw,
   input  logic          served,
   output logic          X,
   output logic          present,
   output logic [QW-1:0] car_count
);

   localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
   localparam logic [DCNT_W-1:0] DCNT_ONE  = {{(DCNT_W-1){1'b0}}, 1'b1};
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE - 1);
   localparam logic [QW-1:0]     CNT_ZERO  = {QW{1'b0}};
   localparam logic [QW-1:0]     CNT_ONE   = {{(QW-1){1'b0}}, 1'b1};
   localparam logic [QW-1:0]     CNT_MAX   = {QW{1'b1}};

   logic              sensor_s;
   logic              arrival_s;
   det_state_t        state_r;
   logic [DCNT_W-1:0] dcnt_r;
   logic [QW-1:0]     car_count_r;
   logic              served_q_r;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sensor_sync (
      .clk (clk),
      .clr (clr),
      .d   (sensor_raw),
      .q   (sensor_s)
   );

   // A vehicle arrives on the edge that completes qualification of a high level
   always_comb begin
      arrival_s = 1'b0;
      if ((state_r == QUAL_ON) && sensor_s && (dcnt_r == DCNT_LAST)) begin
         arrival_s = 1'b1;
      end else begin
         arrival_s = 1'b0;
      end
   end

   // Debounce FSM: a level change is accepted only after DEBOUNCE stable cycles
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_r <= IDLE;
         dcnt_r  <= DCNT_ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (sensor_s) begin
                  state_r <= QUAL_ON;
                  dcnt_r  <= DCNT_ONE;
               end
            end
            QUAL_ON: begin
               if (!sensor_s) begin
                  state_r <= IDLE;
                  dcnt_r  <= DCNT_ZERO;
               end else if (dcnt_r == DCNT_LAST) begin
                  state_r <= PRESENT;
                  dcnt_r  <= DCNT_ZERO;
               end else begin
                  dcnt_r  <= dcnt_r + DCNT_ONE;
               end
            end
            PRESENT: begin
               if (!sensor_s) begin
                  state_r <= QUAL_OFF;
                  dcnt_r  <= DCNT_ONE;
               end
            end
            QUAL_OFF: begin
               // A bounce back high returns to PRESENT without a second arrival
               if (sensor_s) begin
                  state_r <= PRESENT;
                  dcnt_r  <= DCNT_ZERO;
               end else if (dcnt_r == DCNT_LAST) begin
                  state_r <= IDLE;
                  dcnt_r  <= DCNT_ZERO;
               end else begin
                  dcnt_r  <= dcnt_r + DCNT_ONE;
               end
            end
            default: begin
               state_r <= IDLE;
               dcnt_r  <= DCNT_ZERO;
            end
         endcase
      end
   end

   // Remember last cycle's served level to spot the end of a green phase
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         served_q_r <= 1'b0;
      end else begin
         served_q_r <= served;
      end
   end

   // Waiting-vehicle count: cleared on green, re-armed if a car is still on the loop
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         car_count_r <= CNT_ZERO;
      end else if (served) begin
         car_count_r <= CNT_ZERO;
      end else if (served_q_r && present) begin
         car_count_r <= CNT_ONE;
      end else if (arrival_s && (car_count_r != CNT_MAX)) begin
         car_count_r <= car_count_r + CNT_ONE;
      end
   end

   assign present   = (state_r == PRESENT) || (state_r == QUAL_OFF);
   assign X         = (car_count_r != CNT_ZERO);
   assign car_count = car_count_r;

endmodule

// File: doc/vehicle_detector.md
Name: vehicle_detector

Overview:
- Upstream stage of the highway/country signal controller; produces its country-road car-present input `X`.
- Synchronises and debounces the raw country-road loop sensor, and counts vehicles waiting.
- Holds the request until the controller reports the country road served.
- Rejects sensor glitches so the controller never sees a spurious `X` pulse.

Parameters:
- SYNC_STAGES, 2, flops in the sensor synchroniser (minimum 2).
- DEBOUNCE, 4, consecutive synchronised cycles required to accept a level change (minimum 2).
- DCNT_W, 3, debounce counter width; must hold DEBOUNCE-1.
- QW, 4, waiting-vehicle counter width.

Ports:
- clk  in  1  system clock, all flops rising-edge.
- clr  in  1  reset, asynchronous, active-low.
- sensor_raw  in  1  asynchronous loop-sensor level, 1 = vehicle over loop.
- served  in  1  high while the country road shows green (decoded from the controller's country output).
- X  out  1  request to the signal controller; 1 = at least one vehicle waiting.
- present  out  1  debounced sensor level.
- car_count  out  QW  vehicles waiting, saturating.

Behaviour:
- Reset (clr=0, async):
  - synchroniser flops, debounce counter, car_count ← 0
  - FSM ← IDLE
  - X = 0, present = 0
  - Release is synchronous to clk via normal flop behaviour; no other reset-exit sequencing.
- Synchroniser: sensor_s = sensor_raw delayed SYNC_STAGES edges.
- Debounce FSM (states IDLE, QUAL_ON, PRESENT, QUAL_OFF; dcnt is the debounce counter):
  - IDLE:
    - sensor_s=1 → QUAL_ON, dcnt=1.
  - QUAL_ON:
    - sensor_s=0 → IDLE, dcnt=0.
    - sensor_s=1 and dcnt==DEBOUNCE-1 → PRESENT, assert internal arrival.
    - else dcnt+1.
  - PRESENT:
    - sensor_s=0 → QUAL_OFF, dcnt=1.
  - QUAL_OFF:
    - sensor_s=1 → PRESENT, dcnt=0; no new arrival.
    - sensor_s=0 and dcnt==DEBOUNCE-1 → IDLE.
    - else dcnt+1.
- present = state is PRESENT or QUAL_OFF (decoded from registered state).
- car_count update, priority order each edge:
  1. served=1: car_count ← 0; arrival ignored (vehicle proceeds on green).
  2. served falling (served_q=1, served=0) while present=1: car_count ← 1 (vehicle still on loop keeps its request).
  3. arrival: car_count ← car_count+1, saturating at 2^QW-1.
  4. else hold.
- X = (car_count != 0), decoded from registers; no combinational path from any input.
- Latency, SYNC_STAGES=2:
  - sensor_raw first sampled high at edge k and held → X high after edge k+DEBOUNCE+1.
  - Any sensor_s high run shorter than DEBOUNCE cycles never produces an arrival.
- served rising: X low after that same edge.
- Reset mid-operation, any state: everything zero immediately, no arrival pulse on exit.
- Sensor held high indefinitely: exactly one arrival.

Decomposition:
- Shared package `traffic_pkg`:
  - FSM state localparams (IDLE=2'd0, QUAL_ON=2'd1, PRESENT=2'd2, QUAL_OFF=2'd3)
  - the country-road GREEN encoding used to derive `served` at the top level.
- One sub-module, `sync_ff`: parameterised SYNC_STAGES flop chain with async active-low clr, reusable for other asynchronous inputs.

Test Plan (DEBOUNCE=4, QW=4, SYNC_STAGES=2):
1. Hold clr=0 with sensor_raw=1 → X=0, present=0, car_count=0 throughout; release clr → X rises DEBOUNCE+1 edges after the first sampling edge.
2. sensor_raw high for 3 cycles, then low → state returns to IDLE; X and present never assert; car_count=0.
3. sensor_raw high for 10 cycles → present=1, car_count=1, X=1 at edge k+5. Drop for 2 cycles, re-raise → car_count stays 1.
4. Three separate 8-cycle vehicles (gaps of 8) → car_count=3. served=1 for 1 cycle → car_count=0 and X=0 after that edge.
5. 17 separate vehicles, served=0 → car_count saturates at 15, X=1.
6. Vehicle present, served pulses 1→0 while sensor still high → car_count=1, X=1. Then clr=0 mid-QUAL_ON → all outputs 0, no arrival after release.
